// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps pwm8b duty toward a target in clamped steps (clk, rst, start, target, step_size, step_div -> busy, done, pwm_en, value_out)
module pwm_fade_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       target,
  input  logic [7:0]       step_size,
  input  logic [DIV_W-1:0] step_div,
  output logic             busy,
  output logic             done,
  output logic             pwm_en,
  output logic [7:0]       value_out
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t           state;
  logic [DIV_W-1:0] cnt, div_l;
  logic [7:0]       tgt_l, step_l, stepped;
  logic [8:0]       sum, diff;
  always_comb begin
    sum     = {1'b0, value_out} + {1'b0, step_l};
    diff    = {1'b0, value_out} - {1'b0, step_l};
    stepped = state == UP ? (sum > {1'b0, tgt_l} ? tgt_l : sum[7:0])
                          : ((diff[8] || diff[7:0] < tgt_l) ? tgt_l : diff[7:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div_l     <= '0;
      tgt_l     <= '0;
      step_l    <= '0;
      value_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pwm_en    <= 1'b0;
    end else if (start) begin
      tgt_l  <= target;
      step_l <= step_size == 8'd0 ? 8'd1 : step_size;
      div_l  <= step_div;
      cnt    <= '0;
      state  <= target > value_out ? UP : target < value_out ? DOWN : IDLE;
      busy   <= target != value_out;
      done   <= target == value_out;
      pwm_en <= value_out != 8'd0 || target != value_out;
    end else if (state != IDLE && cnt == div_l) begin
      cnt       <= '0;
      value_out <= stepped;
      state     <= stepped == tgt_l ? IDLE : state;
      busy      <= stepped != tgt_l;
      done      <= stepped == tgt_l;
      pwm_en    <= stepped != 8'd0 || stepped != tgt_l;
    end else begin
      cnt  <= state != IDLE ? cnt + 1'b1 : cnt;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed and random checks of pwm_fade_ctrl against a cycle-scheduled reference model
module tb_pwm_fade_ctrl;
  logic        clk = 0, rst = 0, start = 0;
  logic [7:0]  target = 0, step_size = 0;
  logic [15:0] step_div = 0;
  logic        busy, done, pwm_en;
  logic [7:0]  value_out;
  int total = 0, passed = 0, cyc = 0;
  int m_val = 0, m_tgt = 0, m_step = 1, m_next = 0, m_div = 0;
  bit m_busy = 0, m_done = 0, m_en = 0;
  int done_cyc = -1;
  pwm_fade_ctrl #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .step_size(step_size),
    .step_div(step_div), .busy(busy), .done(done), .pwm_en(pwm_en), .value_out(value_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic model;
    cyc++;
    if (rst) begin
      m_val = 0; m_busy = 0; m_done = 0;
    end else if (start) begin
      m_tgt = target; m_step = step_size == 0 ? 1 : step_size; m_div = step_div;
      m_done = (m_tgt == m_val); m_busy = !m_done; m_next = cyc + m_div + 1;
    end else if (m_busy && cyc == m_next) begin
      m_val = m_val < m_tgt ? ((m_val + m_step > m_tgt) ? m_tgt : m_val + m_step)
                            : ((m_val - m_step < m_tgt) ? m_tgt : m_val - m_step);
      m_done = (m_val == m_tgt); m_busy = !m_done; m_next = cyc + m_div + 1;
    end else m_done = 0;
    m_en = !rst && (m_val != 0 || m_busy);
    if (m_done) done_cyc = cyc;
  endtask
  task automatic tick(input logic s, input int t, input int ss, input int d, input logic r);
    start = s; target = 8'(t); step_size = 8'(ss); step_div = 16'(d); rst = r;
    @(posedge clk);
    model;
    #1;
    check("value", value_out, m_val);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("pwm_en", pwm_en, m_en);
    @(negedge clk);
    start = 0; rst = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, $urandom_range(255), $urandom_range(255), $urandom_range(7), 0);
  endtask
  task automatic run_until_val(input string tag, input int v, input int bound);
    int n = 0;
    while (m_val != v && n < bound) begin idle(1); n++; end
    check(tag, m_val, v);
  endtask
  task automatic go(input int t, input int ss, input int d);
    tick(1, t, ss, d, 0);
  endtask
  initial begin
    int k, busy_cnt;
    tick(0, 0, 0, 0, 1);
    check("reset_value", value_out, 0);
    // T1: 0 -> 100 step 10, one step every 4 clocks, done at k+40
    go(100, 10, 3);
    k = cyc; done_cyc = -1; busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin idle(1); busy_cnt += busy; end
    check("t1_done_cycle", done_cyc - k, 40);
    check("t1_busy_len", busy_cnt, 39);
    check("t1_final", value_out, 100);
    // T2: 200 -> 0 step 30 every edge
    go(200, 255, 0); idle(2);
    go(0, 30, 0);
    k = cyc; idle(10);
    check("t2_done_cycle", done_cyc - k, 7);
    check("t2_en_low", pwm_en, 0);
    // T3: 250 -> 255 no wrap, then step 0 treated as 1
    go(250, 255, 0); idle(2);
    go(255, 10, 0); idle(2);
    check("t3_no_wrap", value_out, 255);
    go(0, 255, 0); idle(2);
    go(3, 0, 0); k = cyc; idle(5);
    check("t3_step0_cycles", done_cyc - k, 3);
    // T4: start with target equal to current value
    go(50, 255, 0); idle(3);
    go(50, 7, 2);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    idle(1);
    check("t4_done_once", done, 0);
    check("t4_value", value_out, 50);
    // T5: reverse mid-ramp
    go(0, 255, 0); idle(2);
    go(200, 5, 1);
    run_until_val("t5_reach60", 60, 100);
    done_cyc = -1;
    go(20, 5, 1); k = cyc;
    idle(30);
    check("t5_done_cycle", done_cyc - k, 16);
    check("t5_final", value_out, 20);
    // T6: reset mid-ramp
    go(200, 10, 0);
    run_until_val("t6_reach80", 80, 50);
    tick(1, 255, 1, 0, 1);
    check("t6_rst_value", value_out, 0);
    check("t6_rst_en", pwm_en, 0);
    go(30, 10, 0); idle(5);
    check("t6_after", value_out, 30);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(99);
      if (r < 1) tick($urandom_range(1), $urandom_range(255), $urandom_range(60), $urandom_range(3), 1);
      else if (r < 8) tick(1, r < 3 ? m_val : $urandom_range(255), $urandom_range(60), $urandom_range(3), 0);
      else idle(1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
